// File: rtl/instr_controller.sv
// instr_controller: multi-cycle fetch/decode/execute sequencer for a small
// 16-bit instruction set. It drives the instruction memory, the data memory
// and the register-file/ALU controls. Every output is a Moore decode of the
// current state and the latched instruction register.
module instr_controller #(
    parameter int PC_WIDTH = 7
) (
    input  logic                clk,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] I_addr,
    input  logic [15:0]         I_data,
    output logic [7:0]          D_addr,
    output logic                Dmem_write,
    output logic                Reg_write,
    output logic [4:0]          Reg_w_addr,
    output logic [4:0]          Reg_Ra_addr,
    output logic [4:0]          Reg_Rb_addr,
    output logic [1:0]          RF_s,
    output logic [7:0]          RF_W_data,
    output logic [2:0]          ALU_s,
    output logic                halted
);

    typedef enum logic [3:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_NOOP,
        S_LOAD_A,
        S_LOAD_B,
        S_STORE,
        S_ADD,
        S_SUB,
        S_LOADC,
        S_HALT
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PC_WIDTH-1:0] r_pc;
    // Only the operand field is kept: the opcode is already encoded in the
    // execute state chosen during DECODE.
    logic [11:0]         r_ir;

    assign I_addr = r_pc;

    // State, program counter and instruction register; HALT freezes PC/IR
    // simply because only DECODE updates them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_INIT;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_ir <= I_data[11:0];
                r_pc <= r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // Next-state selection and Moore output decode; unused outputs stay 0.
    always_comb begin
        w_next      = r_state;
        D_addr      = '0;
        Dmem_write  = 1'b0;
        Reg_write   = 1'b0;
        Reg_w_addr  = '0;
        Reg_Ra_addr = '0;
        Reg_Rb_addr = '0;
        RF_s        = 2'b00;
        RF_W_data   = '0;
        ALU_s       = 3'b000;
        halted      = 1'b0;
        case (r_state)
            S_INIT:   w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (I_data[15:12])
                    4'h0:    w_next = S_NOOP;
                    4'h1:    w_next = S_STORE;
                    4'h2:    w_next = S_LOAD_A;
                    4'h3:    w_next = S_ADD;
                    4'h4:    w_next = S_SUB;
                    4'h5:    w_next = S_LOADC;
                    4'h6:    w_next = S_HALT;
                    default: w_next = S_NOOP;
                endcase
            end
            S_NOOP:   w_next = S_FETCH;
            S_STORE: begin
                D_addr      = r_ir[11:4];
                Reg_Ra_addr = {1'b0, r_ir[3:0]};
                Dmem_write  = 1'b1;
                w_next      = S_FETCH;
            end
            S_LOAD_A: begin
                // Present the address; the data memory returns it next cycle.
                D_addr = r_ir[11:4];
                w_next = S_LOAD_B;
            end
            S_LOAD_B: begin
                D_addr     = r_ir[11:4];
                Reg_write  = 1'b1;
                Reg_w_addr = {1'b0, r_ir[3:0]};
                RF_s       = 2'b01;
                w_next     = S_FETCH;
            end
            S_ADD: begin
                Reg_Ra_addr = {1'b0, r_ir[11:8]};
                Reg_Rb_addr = {1'b0, r_ir[7:4]};
                Reg_w_addr  = {1'b0, r_ir[3:0]};
                ALU_s       = 3'b001;
                Reg_write   = 1'b1;
                w_next      = S_FETCH;
            end
            S_SUB: begin
                Reg_Ra_addr = {1'b0, r_ir[11:8]};
                Reg_Rb_addr = {1'b0, r_ir[7:4]};
                Reg_w_addr  = {1'b0, r_ir[3:0]};
                ALU_s       = 3'b010;
                Reg_write   = 1'b1;
                w_next      = S_FETCH;
            end
            S_LOADC: begin
                RF_W_data  = r_ir[11:4];
                RF_s       = 2'b10;
                Reg_w_addr = {1'b0, r_ir[3:0]};
                Reg_write  = 1'b1;
                w_next     = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                w_next = S_HALT;
            end
            default:  w_next = S_INIT;
        endcase
    end

endmodule

// File: tb/tb_instr_controller.sv
// Bench for instr_controller: a synchronous instruction ROM is emulated in
// the stimulus process, and each instruction's cycle-by-cycle output vector is
// predicted from the instruction's fields and the model program counter.
module tb_instr_controller;

    localparam int PH_NONE   = 0;
    localparam int PH_FETCH  = 1;
    localparam int PH_DECODE = 2;
    localparam int PH_NOOP   = 3;
    localparam int PH_STORE  = 4;
    localparam int PH_LOADA  = 5;
    localparam int PH_LOADB  = 6;
    localparam int PH_ADD    = 7;
    localparam int PH_SUB    = 8;
    localparam int PH_LOADC  = 9;
    localparam int PH_HALT   = 10;

    logic        clk;
    logic        reset;
    logic [6:0]  I_addr;
    logic [15:0] I_data;
    logic [7:0]  D_addr;
    logic        Dmem_write;
    logic        Reg_write;
    logic [4:0]  Reg_w_addr;
    logic [4:0]  Reg_Ra_addr;
    logic [4:0]  Reg_Rb_addr;
    logic [1:0]  RF_s;
    logic [7:0]  RF_W_data;
    logic [2:0]  ALU_s;
    logic        halted;

    logic [15:0] mem [128];
    logic [6:0]  m_pc;
    int          n_pass;
    int          n_fail;
    int          n_total;

    instr_controller #(.PC_WIDTH(7)) dut (
        .clk         (clk),
        .reset       (reset),
        .I_addr      (I_addr),
        .I_data      (I_data),
        .D_addr      (D_addr),
        .Dmem_write  (Dmem_write),
        .Reg_write   (Reg_write),
        .Reg_w_addr  (Reg_w_addr),
        .Reg_Ra_addr (Reg_Ra_addr),
        .Reg_Rb_addr (Reg_Rb_addr),
        .RF_s        (RF_s),
        .RF_W_data   (RF_W_data),
        .ALU_s       (ALU_s),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for one cycle of an instruction, built from its fields.
    function automatic logic [45:0] exp_vec(input int ph, input logic [15:0] w,
                                            input logic [6:0] pc);
        logic [7:0] da;
        logic       dw;
        logic       rw;
        logic [4:0] wa;
        logic [4:0] ra;
        logic [4:0] rb;
        logic [1:0] rfs;
        logic [7:0] rfd;
        logic [2:0] alu;
        logic       h;
        da = 8'h00; dw = 1'b0; rw = 1'b0; wa = 5'd0; ra = 5'd0; rb = 5'd0;
        rfs = 2'b00; rfd = 8'h00; alu = 3'b000; h = 1'b0;
        case (ph)
            PH_STORE: begin da = w[11:4]; ra = {1'b0, w[3:0]}; dw = 1'b1; end
            PH_LOADA: da = w[11:4];
            PH_LOADB: begin da = w[11:4]; rw = 1'b1; wa = {1'b0, w[3:0]}; rfs = 2'b01; end
            PH_ADD: begin
                ra = {1'b0, w[11:8]}; rb = {1'b0, w[7:4]}; wa = {1'b0, w[3:0]};
                alu = 3'b001; rw = 1'b1;
            end
            PH_SUB: begin
                ra = {1'b0, w[11:8]}; rb = {1'b0, w[7:4]}; wa = {1'b0, w[3:0]};
                alu = 3'b010; rw = 1'b1;
            end
            PH_LOADC: begin rfd = w[11:4]; rfs = 2'b10; wa = {1'b0, w[3:0]}; rw = 1'b1; end
            PH_HALT: h = 1'b1;
            default: ;
        endcase
        return {pc, da, dw, rw, wa, ra, rb, rfs, rfd, alu, h};
    endfunction

    // One clock: the ROM answers the address seen before the edge.
    task automatic step();
        logic [6:0] a;
        a = I_addr;
        @(posedge clk);
        #1;
        I_data = mem[a];
    endtask

    task automatic check(input string tag, input logic [45:0] expv);
        logic [45:0] obs;
        obs = {I_addr, D_addr, Dmem_write, Reg_write, Reg_w_addr, Reg_Ra_addr,
               Reg_Rb_addr, RF_s, RF_W_data, ALU_s, halted};
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (pc %0d)", tag, obs, expv, m_pc);
        end
        n_total++;
        assert ((Dmem_write & Reg_write) === 1'b0) n_pass++;
        else begin
            n_fail++;
            $error("FAIL strobe_excl_%s: observed Dmem_write=%b Reg_write=%b expected not both 1",
                   tag, Dmem_write, Reg_write);
        end
    endtask

    // Run the instruction at the model PC from FETCH through its last state.
    task automatic run_instr();
        logic [15:0] w;
        w = mem[m_pc];
        step(); check("fetch", exp_vec(PH_FETCH, w, m_pc));
        step(); check("decode", exp_vec(PH_DECODE, w, m_pc));
        m_pc = m_pc + 7'd1;
        case (w[15:12])
            4'h1: begin step(); check("store", exp_vec(PH_STORE, w, m_pc)); end
            4'h2: begin
                step(); check("load_a", exp_vec(PH_LOADA, w, m_pc));
                step(); check("load_b", exp_vec(PH_LOADB, w, m_pc));
            end
            4'h3: begin step(); check("add", exp_vec(PH_ADD, w, m_pc)); end
            4'h4: begin step(); check("sub", exp_vec(PH_SUB, w, m_pc)); end
            4'h5: begin step(); check("loadc", exp_vec(PH_LOADC, w, m_pc)); end
            4'h6: begin
                for (int k = 0; k < 22; k++) begin
                    step(); check("halt", exp_vec(PH_HALT, w, m_pc));
                end
            end
            default: begin step(); check("noop", exp_vec(PH_NOOP, w, m_pc)); end
        endcase
    endtask

    initial begin
        logic [3:0] op;
        int         r;
        n_pass = 0; n_fail = 0; n_total = 0;
        reset  = 1'b1;
        I_data = 16'h0000;
        m_pc   = 7'd0;
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;

        // Directed program followed by random non-HALT instructions.
        mem[0] = 16'h5AB3; mem[1] = 16'h2104; mem[2] = 16'h3125; mem[3] = 16'h4125;
        mem[4] = 16'h1FF7; mem[5] = 16'hF000; mem[6] = 16'h0000;
        for (int i = 7; i < 57; i++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'h6) op = 4'h3;
            mem[i] = {op, 12'($urandom)};
        end
        mem[57] = 16'h2104;

        step(); step();
        check("reset", exp_vec(PH_NONE, 16'h0000, 7'd0));
        reset = 1'b0;
        for (int i = 0; i < 57; i++) run_instr();

        // Reset arrives while a LOAD sits in LOAD_A: no register write follows.
        step(); check("fetch", exp_vec(PH_FETCH, mem[57], m_pc));
        step(); check("decode", exp_vec(PH_DECODE, mem[57], m_pc));
        m_pc = m_pc + 7'd1;
        step(); check("load_a", exp_vec(PH_LOADA, mem[57], m_pc));
        reset = 1'b1;
        step(); check("reset_mid_load", exp_vec(PH_NONE, 16'h0000, 7'd0));
        reset = 1'b0;
        m_pc  = 7'd0;

        // PC wrap: 127 NOOP-class words then 0xF000 at the last address.
        for (int i = 0; i < 127; i++) begin
            r = $urandom_range(0, 9);
            op = (r == 0) ? 4'h0 : 4'(r + 6);
            mem[i] = {op, 12'($urandom)};
        end
        mem[127] = 16'hF000;
        for (int i = 0; i < 128; i++) run_instr();

        // HALT at address 0 after the wrap, then reset out of it.
        mem[0] = 16'h6000;
        run_instr();
        reset = 1'b1;
        step(); check("reset_from_halt", exp_vec(PH_NONE, 16'h0000, 7'd0));
        reset = 1'b0;
        step(); check("first_fetch", exp_vec(PH_FETCH, 16'h0000, 7'd0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
